multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core datapath (register file, immediate generator, ALU, PC register, instruction register). It walks each instruction through FETCH/DECODE/EXEC/MEM/WB states, handshakes with instruction and data memory, and drives the PC, IR, register-file and mux-select enables. Decode covers the same opcode set the immediate generator supports; any other opcode traps. A retired-instruction counter is included for bring-up and verification.

## Interface
- No parameters.
- i_clk  in  1  core clock; all state changes on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_instr  in  32  instruction register contents (opcode = i_instr[6:0])
- i_imem_ack  in  1  instruction memory ack; instruction valid for IR load this cycle
- i_dmem_ack  in  1  data memory ack; load data valid / store accepted this cycle
- i_br_taken  in  1  branch comparator result, valid in EXEC
- o_imem_req  out  1  instruction fetch request
- o_ir_en  out  1  IR load enable
- o_dmem_req  out  1  data memory request
- o_dmem_we  out  1  data memory write (store)
- o_rd_wren  out  1  register file write enable
- o_pc_en  out  1  PC update enable
- o_pc_sel  out  1  0 = PC+4, 1 = PC+imm
- o_alu_a_sel  out  1  0 = rs1, 1 = PC
- o_alu_b_sel  out  1  0 = rs2, 1 = imm
- o_wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm
- o_state  out  3  current state encoding
- o_illegal  out  1  sticky illegal-opcode flag
- o_retired  out  32  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6/7 unreachable, recover to FETCH.
- Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, 0010111 AUIPC. All others (incl. JALR, 0x00000000) illegal.
- FETCH: o_imem_req=1 held until i_imem_ack; ack cycle: o_ir_en=1, next DECODE.
- DECODE: one cycle; legal -> EXEC, illegal -> TRAP.
- EXEC: one cycle. LOAD/STORE -> MEM. BRANCH -> FETCH with o_pc_en=1, o_pc_sel=i_br_taken. Others -> WB.
- MEM: o_dmem_req=1, o_dmem_we=1 for STORE only; held until i_dmem_ack. Ack: STORE -> FETCH with o_pc_en=1, o_pc_sel=0; LOAD -> WB.
- WB: o_rd_wren=1, o_pc_en=1, o_pc_sel=1 for JAL else 0; next FETCH.
- TRAP: absorbing until reset; o_illegal=1; every enable/request output 0.
- Selects (combinational from opcode, meaningful in DECODE..WB): alu_a_sel=1 for AUIPC/JAL/BRANCH; alu_b_sel=1 for all except R and BRANCH; wb_sel=01 LOAD, 10 JAL, 11 LUI, else 00.
- o_retired increments by 1 on every cycle with o_pc_en=1; wraps 0xFFFFFFFF -> 0.
- Acks in states not requesting that memory are ignored.

## Timing
- Reset (i_rst_n=0 at edge): state=FETCH, o_illegal=0, o_retired=0. Cycle after release: o_imem_req=1, all other enables 0, selects 0.
- All enables/requests are combinational from registered state (+ ack/opcode); no output register stage.
- Zero-wait memory (ack same cycle as req): R/I/LUI/AUIPC/JAL 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each memory wait cycle adds 1.
- o_pc_en and o_ir_en never asserted in the same cycle; at most one of o_imem_req/o_dmem_req high per cycle.
- Reset mid-operation: any pending request is dropped the same edge; no partial write completes after reset (o_rd_wren/o_dmem_we 0 from the next cycle).

## Test plan
- Reset 3 cycles, release, ack immediately, instr 0x003100B3 (add x1,x2,x3) -> states 0,1,2,4,0; o_rd_wren=1 only in WB, wb_sel=00, alu_b_sel=0; o_retired=1.
- 0x00402283 (lw x5,4(x0)) with i_dmem_ack delayed 3 cycles -> MEM held 4 cycles with o_dmem_req=1, o_dmem_we=0; then WB, wb_sel=01; total 8 cycles.
- 0x00502423 (sw x5,8(x0)) -> MEM with o_dmem_we=1, o_dmem_req=1; no o_rd_wren; o_pc_en on ack; 4 cycles.
- 0x00000463 (beq) with i_br_taken=1 then =0 -> 3 cycles each; o_pc_sel=1 then 0; o_rd_wren never 1.
- Instr 0x00000000 -> TRAP after DECODE, o_illegal=1 sticky, all requests 0 for 20 cycles despite acks; reset clears to FETCH.
- Preload o_retired=0xFFFFFFFF via 2^32 path skipped: force via long run in sim or check wrap with backdoor; reset asserted mid-MEM of a store -> o_dmem_we=0 next cycle, state=FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Sequencing controller for a multi-cycle RV32I datapath. Walks each
// instruction through FETCH / DECODE / EXEC / MEM / WB, handshakes with the
// instruction and data memories, and drives the PC, IR, register-file and
// datapath mux-select enables. Unsupported opcodes park the core in TRAP
// until reset. A retired-instruction counter is kept for bring-up.
//
// All enables, requests and selects are combinational from the registered
// state, the opcode and the memory acks, so the datapath sees them in the
// same cycle the state is entered.

module multicycle_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic        i_br_taken,
  output logic        o_imem_req,
  output logic        o_ir_en,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_rd_wren,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic [31:0] o_retired
);

  // State encoding; 6 and 7 are never entered and fall back to FETCH.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Opcodes the immediate generator supports; everything else traps.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Writeback source encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        illegal;
  logic [31:0] retired;

  logic [6:0]  opcode;
  logic        is_r;
  logic        is_i_alu;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jal;
  logic        is_lui;
  logic        is_auipc;
  logic        is_legal;
  logic        is_mem_op;

  logic        in_datapath_state;
  logic        imem_req;
  logic        ir_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        rd_wren;
  logic        pc_en;
  logic        pc_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;

  assign opcode = i_instr[6:0];

  // Opcode classification from the instruction register contents
  always_comb begin
    is_r      = (opcode == OP_R);
    is_i_alu  = (opcode == OP_I_ALU);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    is_legal  = is_r | is_i_alu | is_load | is_store |
                is_branch | is_jal | is_lui | is_auipc;
    is_mem_op = is_load | is_store;
  end

  // Next-state sequencing; memory states hold until their ack arrives
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (i_imem_ack) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (i_dmem_ack) begin
          if (is_store) begin
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // State register; reset drops any in-flight request on the same edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Sticky illegal flag, set as DECODE rejects the opcode
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      illegal <= 1'b0;
    end else if (state == S_DECODE && !is_legal) begin
      illegal <= 1'b1;
    end
  end

  // Enables and requests; TRAP and the unused codes drive everything low
  always_comb begin
    imem_req = 1'b0;
    ir_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rd_wren  = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = i_imem_ack;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_en  = 1'b1;
          pc_sel = i_br_taken;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (i_dmem_ack && is_store) begin
          pc_en  = 1'b1;
          pc_sel = 1'b0;
        end
      end
      S_WB: begin
        rd_wren = 1'b1;
        pc_en   = 1'b1;
        pc_sel  = is_jal;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Datapath mux selects, only driven while an instruction is in flight
  always_comb begin
    in_datapath_state = (state == S_DECODE) || (state == S_EXEC) ||
                        (state == S_MEM)    || (state == S_WB);
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = WB_ALU;
    if (in_datapath_state) begin
      alu_a_sel = is_auipc | is_jal | is_branch;
      alu_b_sel = !(is_r | is_branch);
      if (is_load) begin
        wb_sel = WB_LOAD;
      end else if (is_jal) begin
        wb_sel = WB_PC4;
      end else if (is_lui) begin
        wb_sel = WB_IMM;
      end else begin
        wb_sel = WB_ALU;
      end
    end
  end

  // Retired-instruction counter; every PC update retires one instruction
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      retired <= 32'd0;
    end else if (pc_en) begin
      retired <= retired + 32'd1;
    end
  end

  assign o_imem_req  = imem_req;
  assign o_ir_en     = ir_en;
  assign o_dmem_req  = dmem_req;
  assign o_dmem_we   = dmem_we;
  assign o_rd_wren   = rd_wren;
  assign o_pc_en     = pc_en;
  assign o_pc_sel    = pc_sel;
  assign o_alu_a_sel = alu_a_sel;
  assign o_alu_b_sel = alu_b_sel;
  assign o_wb_sel    = wb_sel;
  assign o_state     = state;
  assign o_illegal   = illegal;
  assign o_retired   = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Randomized bench for multicycle_ctrl. Each instruction is turned into the
// expected phase sequence (FETCH waits, DECODE, EXEC, MEM waits, WB) from its
// opcode class and the chosen memory latencies, and every cycle's outputs are
// compared against that sequence.

module tb_multicycle_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_instr;
  logic        i_imem_ack;
  logic        i_dmem_ack;
  logic        i_br_taken;
  logic        o_imem_req;
  logic        o_ir_en;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        o_rd_wren;
  logic        o_pc_en;
  logic        o_pc_sel;
  logic        o_alu_a_sel;
  logic        o_alu_b_sel;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_state;
  logic        o_illegal;
  logic [31:0] o_retired;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = 32'd0;

  logic [6:0]  legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

  multicycle_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_instr     (i_instr),
    .i_imem_ack  (i_imem_ack),
    .i_dmem_ack  (i_dmem_ack),
    .i_br_taken  (i_br_taken),
    .o_imem_req  (o_imem_req),
    .o_ir_en     (o_ir_en),
    .o_dmem_req  (o_dmem_req),
    .o_dmem_we   (o_dmem_we),
    .o_rd_wren   (o_rd_wren),
    .o_pc_en     (o_pc_en),
    .o_pc_sel    (o_pc_sel),
    .o_alu_a_sel (o_alu_a_sel),
    .o_alu_b_sel (o_alu_b_sel),
    .o_wb_sel    (o_wb_sel),
    .o_state     (o_state),
    .o_illegal   (o_illegal),
    .o_retired   (o_retired)
  );

  // Free-running 100 MHz clock
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iack, input logic dack, input logic br);
    i_imem_ack = iack;
    i_dmem_ack = dack;
    i_br_taken = br;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic bit is_legal_op(input logic [6:0] op);
    bit hit = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) hit = 1'b1;
    return hit;
  endfunction

  // One instruction, with iw FETCH wait cycles and dw MEM wait cycles
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw, input logic br);
    logic [6:0] op;
    bit is_ld, is_st, is_br, is_jal, is_lui, is_auipc, is_r, has_mem, has_wb;
    logic       exp_a, exp_b, exp_pc_sel;
    logic [1:0] exp_wb;
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int         len, mem_last;
    logic       iack, dack, brv;

    op       = instr[6:0];
    is_ld    = (op == 7'b0000011);
    is_st    = (op == 7'b0100011);
    is_br    = (op == 7'b1100011);
    is_jal   = (op == 7'b1101111);
    is_lui   = (op == 7'b0110111);
    is_auipc = (op == 7'b0010111);
    is_r     = (op == 7'b0110011);
    has_mem  = is_ld || is_st;
    has_wb   = !is_br && !is_st;

    exp_a      = is_auipc || is_jal || is_br;
    exp_b      = !(is_r || is_br);
    exp_wb     = is_ld ? 2'b01 : is_jal ? 2'b10 : is_lui ? 2'b11 : 2'b00;
    exp_pc_sel = is_br ? br : is_jal;

    for (int i = 0; i <= iw; i++) exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    if (has_mem) for (int i = 0; i <= dw; i++) exp_q.push_back(3'd3);
    if (has_wb) exp_q.push_back(3'd4);
    len      = exp_q.size();
    mem_last = iw + 3 + dw;

    i_instr = instr;
    checkOutput("start_retired", o_retired, exp_retired);
    for (int idx = 0; idx < len; idx++) begin
      e    = exp_q[idx];
      iack = (idx <= iw) ? (idx == iw) : 1'($urandom_range(0, 1));
      dack = (e == 3'd3) ? (idx == mem_last) : 1'($urandom_range(0, 1));
      brv  = is_br ? br : 1'($urandom_range(0, 1));
      applyStimulus(iack, dack, brv);
      #1;
      checkOutput("state", 32'(o_state), 32'(e));
      checkOutput("imem_req", 32'(o_imem_req), 32'(e == 3'd0));
      checkOutput("ir_en", 32'(o_ir_en), 32'(idx == iw));
      checkOutput("dmem_req", 32'(o_dmem_req), 32'(e == 3'd3));
      checkOutput("dmem_we", 32'(o_dmem_we), 32'(e == 3'd3 && is_st));
      checkOutput("rd_wren", 32'(o_rd_wren), 32'(e == 3'd4));
      checkOutput("pc_en", 32'(o_pc_en), 32'(idx == len - 1));
      if (idx == len - 1) checkOutput("pc_sel", 32'(o_pc_sel), 32'(exp_pc_sel));
      if (e != 3'd0) begin
        checkOutput("alu_a_sel", 32'(o_alu_a_sel), 32'(exp_a));
        checkOutput("alu_b_sel", 32'(o_alu_b_sel), 32'(exp_b));
        checkOutput("wb_sel", 32'(o_wb_sel), 32'(exp_wb));
      end
      tick();
    end
    exp_retired = exp_retired + 32'd1;
    checkOutput("end_state", 32'(o_state), 32'd0);
    checkOutput("end_retired", o_retired, exp_retired);
  endtask

  // Illegal opcode: FETCH, DECODE, then TRAP regardless of acks until reset
  task automatic run_illegal(input logic [31:0] instr);
    i_instr = instr;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("ill_fetch_state", 32'(o_state), 32'd0);
    checkOutput("ill_ir_en", 32'(o_ir_en), 32'd1);
    tick();
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #1;
    checkOutput("ill_decode_state", 32'(o_state), 32'd1);
    checkOutput("ill_decode_pc_en", 32'(o_pc_en), 32'd0);
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c == 10) i_instr = 32'h003100B3;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      checkOutput("trap_state", 32'(o_state), 32'd5);
      checkOutput("trap_illegal", 32'(o_illegal), 32'd1);
      checkOutput("trap_outputs",
                  32'({o_imem_req, o_ir_en, o_dmem_req, o_dmem_we, o_rd_wren, o_pc_en}), 32'd0);
      checkOutput("trap_retired", o_retired, exp_retired);
      tick();
    end
    i_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("trap_rst_state", 32'(o_state), 32'd0);
    checkOutput("trap_rst_illegal", 32'(o_illegal), 32'd0);
    checkOutput("trap_rst_retired", o_retired, 32'd0);
    i_rst_n = 1'b1;
    exp_retired = 32'd0;
  endtask

  task automatic run_random(input int count);
    logic [31:0] r;
    logic [6:0]  op;
    for (int n = 0; n < count; n++) begin
      r  = $urandom;
      op = legal_ops[$urandom_range(0, 7)];
      run_instr({r[31:7], op}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [31:0] r;
    i_rst_n = 1'b0;
    i_instr = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    tick(); tick(); tick();
    checkOutput("rst_state", 32'(o_state), 32'd0);
    checkOutput("rst_illegal", 32'(o_illegal), 32'd0);
    checkOutput("rst_retired", o_retired, 32'd0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("rel_imem_req", 32'(o_imem_req), 32'd1);
    checkOutput("rel_enables",
                32'({o_ir_en, o_dmem_req, o_dmem_we, o_rd_wren, o_pc_en}), 32'd0);
    checkOutput("rel_selects", 32'({o_alu_a_sel, o_alu_b_sel, o_wb_sel}), 32'd0);

    run_instr(32'h003100B3, 0, 0, 1'b0);
    run_instr(32'h00402283, 0, 3, 1'b0);
    run_instr(32'h00502423, 0, 0, 1'b0);
    run_instr(32'h00000463, 0, 0, 1'b1);
    run_instr(32'h00000463, 0, 0, 1'b0);
    run_instr(32'h0000006F, 2, 0, 1'b0);
    run_instr(32'h123450B7, 0, 0, 1'b0);

    run_random(150);

    run_illegal(32'h00000000);
    run_random(5);
    run_illegal(32'h000000E7);
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      while (is_legal_op(r[6:0])) r = $urandom;
      run_illegal(r);
      run_random(3);
    end

    // Reset while a store waits in MEM, with an ack on the reset edge
    i_instr = 32'h00502423;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("mid_mem_state", 32'(o_state), 32'd3);
    checkOutput("mid_mem_we", 32'(o_dmem_we), 32'd1);
    tick();
    i_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("mid_rst_state", 32'(o_state), 32'd0);
    checkOutput("mid_rst_dmem_we", 32'(o_dmem_we), 32'd0);
    checkOutput("mid_rst_dmem_req", 32'(o_dmem_req), 32'd0);
    checkOutput("mid_rst_rd_wren", 32'(o_rd_wren), 32'd0);
    checkOutput("mid_rst_retired", o_retired, 32'd0);
    i_rst_n = 1'b1;
    exp_retired = 32'd0;
    tick();
    run_random(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
